// File: rtl/eth_pkg.sv
// Shared receive-path helpers: beat width, size-field width and tkeep mask.
// Used by the RX drain engine and by the receiver that feeds it.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package eth_pkg;

  // Widest beat supported (64-bit stream -> 8 byte lanes).
  localparam int MAX_KEEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_ACK    = 2'd2
  } drain_state_e;

  // Bytes carried by one stream beat.
  function automatic int beat_bytes(int data_width);
    return data_width / 8;
  endfunction

  // Width of a byte-count field able to hold 0..mtu inclusive.
  function automatic int size_width(int mtu);
    return $clog2(mtu + 1);
  endfunction

  // Byte-lane mask for a beat holding 'rem' valid bytes out of 'lanes';
  // rem == 0 means the beat is completely full.
  function automatic logic [MAX_KEEP_W-1:0] keep_mask(int rem, int lanes);
    logic [MAX_KEEP_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < lanes) m[i] = (rem == 0) || (i < rem);
    end
    return m;
  endfunction

endpackage

// File: rtl/eth_rx_drain_fifo.sv
// Two-entry valid/ready FIFO holding returned receiver words ahead of egress.
// Latency: a pushed word is at the head one cycle after the push edge.
// Backpressure: in_rdy drops when both entries are full; head is stable until popped.
//
// Ports: clk_i/reset_n_i clock and async active-low reset; in_vld/in_rdy/in_dat
// write side; out_vld/out_rdy/out_dat read side; count_o current occupancy (0..2).
module eth_rx_drain_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [width_p-1:0] in_dat,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [width_p-1:0] out_dat,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] mem_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         cnt_q;
  logic               push;
  logic               pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ethernet_rx_drain.sv
// Drains complete packets from the RX buffer onto an AXI-stream and acks them.
// Latency: first tvalid 3 cycles after capture; then 1 beat/cycle with tready high.
// Backpressure: tready low stalls the head; reads throttle so the 2-entry FIFO never overflows.
//
// Ports: clk_i/reset_n_i clock and async active-low reset; enable_i gates new captures;
// packet_avail_i/packet_rsize_i packet offer; packet_rvalid_o/packet_raddr_o/packet_rdata_i
// receiver read port (data one cycle after strobe); packet_ack_o release pulse;
// m_axis_* egress stream; drained_count_o saturating count of acked packets.
module ethernet_rx_drain
  import eth_pkg::*;
#(
  parameter int data_width_p  = 64,
  parameter int eth_mtu_p     = 2048,
  parameter int count_width_p = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             enable_i,
  input  logic                             packet_avail_i,
  input  logic [$clog2(eth_mtu_p+1)-1:0]   packet_rsize_i,
  output logic                             packet_rvalid_o,
  output logic [$clog2(eth_mtu_p)-1:0]     packet_raddr_o,
  input  logic [data_width_p-1:0]          packet_rdata_i,
  output logic                             packet_ack_o,
  output logic [data_width_p-1:0]          m_axis_tdata_o,
  output logic [data_width_p/8-1:0]        m_axis_tkeep_o,
  output logic                             m_axis_tvalid_o,
  output logic                             m_axis_tlast_o,
  input  logic                             m_axis_tready_i,
  output logic [count_width_p-1:0]         drained_count_o
);

  localparam int W  = beat_bytes(data_width_p);
  localparam int WL = $clog2(W);
  localparam int SW = size_width(eth_mtu_p);
  localparam int AW = $clog2(eth_mtu_p);

  typedef struct packed {
    logic [data_width_p-1:0] data;
    logic [W-1:0]            keep;
    logic                    last;
  } beat_t;

  drain_state_e           state_q, state_d;
  logic [SW-1:0]          beats_q;       // beats in the current packet
  logic [SW-1:0]          rd_idx_q;      // reads issued so far
  logic [WL-1:0]          rem_q;         // size mod W, sets the final tkeep
  logic                   rd_inflight_q; // a read was issued last cycle
  logic                   rd_last_q;     // ...and it was the packet's final word
  logic [count_width_p-1:0] count_q;

  logic                   capture;
  logic                   rd_fire;
  logic                   pop;
  logic [2:0]             load;
  logic [SW:0]            beats_sum;
  logic [SW-1:0]          beats_cap;
  logic [SW+WL-1:0]       addr_full;
  logic [MAX_KEEP_W-1:0]  last_keep_full;
  beat_t                  wr_beat;
  beat_t                  head;
  logic                   fifo_in_rdy;
  logic                   fifo_out_vld;
  logic [1:0]             fifo_cnt;

  assign capture   = (state_q == ST_IDLE) && enable_i && packet_avail_i;
  assign beats_sum = {1'b0, packet_rsize_i} + (SW+1)'(W - 1);
  assign beats_cap = SW'(beats_sum >> WL);

  // Words already held plus the word arriving this cycle, less the one leaving,
  // must leave room for the word this read will return next cycle.
  assign pop     = fifo_out_vld & m_axis_tready_i;
  assign load    = {1'b0, fifo_cnt} + {2'b0, rd_inflight_q} - {2'b0, pop};
  assign rd_fire = (state_q == ST_STREAM) && (rd_idx_q != beats_q) &&
                   (load < 3'd2) && fifo_in_rdy;

  assign addr_full       = {rd_idx_q, {WL{1'b0}}};
  assign packet_rvalid_o = rd_fire;
  assign packet_raddr_o  = rd_fire ? AW'(addr_full) : '0;

  // Keep/last travel with the read so the FIFO entry is self-describing.
  assign last_keep_full = keep_mask(32'(rem_q), W);
  assign wr_beat.data   = packet_rdata_i;
  assign wr_beat.keep   = rd_last_q ? last_keep_full[W-1:0] : '1;
  assign wr_beat.last   = rd_last_q;

  eth_rx_drain_fifo #(
    .width_p($bits(beat_t))
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .in_vld    (rd_inflight_q),
    .in_rdy    (fifo_in_rdy),
    .in_dat    (wr_beat),
    .out_vld   (fifo_out_vld),
    .out_rdy   (m_axis_tready_i),
    .out_dat   (head),
    .count_o   (fifo_cnt)
  );

  // Bus is held at zero whenever no beat is offered.
  assign m_axis_tvalid_o = fifo_out_vld;
  assign m_axis_tdata_o  = fifo_out_vld ? head.data : '0;
  assign m_axis_tkeep_o  = fifo_out_vld ? head.keep : '0;
  assign m_axis_tlast_o  = fifo_out_vld & head.last;
  assign drained_count_o = count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    packet_ack_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = (packet_rsize_i != '0) ? ST_STREAM : ST_ACK;
      end
      ST_STREAM: begin
        if (pop && head.last) state_d = ST_ACK;
      end
      ST_ACK: begin
        packet_ack_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beats_q       <= '0;
      rd_idx_q      <= '0;
      rem_q         <= '0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      if (capture) begin
        beats_q  <= beats_cap;
        rem_q    <= packet_rsize_i[WL-1:0];
        rd_idx_q <= '0;
      end else if (rd_fire) begin
        rd_idx_q <= rd_idx_q + SW'(1);
      end
      rd_inflight_q <= rd_fire;
      rd_last_q     <= rd_fire && (rd_idx_q == beats_q - SW'(1));
      if (state_q == ST_ACK && count_q != '1) count_q <= count_q + 1'b1;
    end
  end

endmodule
